// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check used at acceptance time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    // Unsigned widths exist only for loads, so BU/HU are illegal when storing.
    function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        legal      = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:  legal = 1'b1;
            F3_H:  begin legal = 1'b1; misaligned = addr_lo[0]; end
            F3_W:  begin legal = 1'b1; misaligned = |addr_lo; end
            F3_BU: legal = !we;
            F3_HU: begin legal = !we; misaligned = addr_lo[0]; end
            default: legal = 1'b0;
        endcase
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word
// and merges sub-word store data into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:  load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_BU: load_data_o = {24'd0, byte_sel};
            F3_HU: load_data_o = {16'd0, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

    // Little-endian merge: only the addressed lane changes.
    always_comb begin
        merged_o = rdata_i;
        case (funct3_i)
            F3_B: begin
                case (addr_lo_i)
                    2'd0: merged_o[7:0]   = wdata_i[7:0];
                    2'd1: merged_o[15:8]  = wdata_i[7:0];
                    2'd2: merged_o[23:16] = wdata_i[7:0];
                    2'd3: merged_o[31:24] = wdata_i[7:0];
                    default: merged_o = rdata_i;
                endcase
            end
            F3_H: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i;
                else              merged_o[15:0]  = wdata_i;
            end
            default: merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-wide data memory with a
// registered read port; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    lsu_align u_align (
        .funct3_i    (funct3_q),
        .addr_lo_i   (addr_q[1:0]),
        .rdata_i     (mem_rdata),
        .wdata_i     (wdata_q[15:0]),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        mem_rw    = 1'b0;
        mem_wdata = 32'd0;
        req_err   = req_error(req_we, req_funct3, req_addr[1:0]);
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    if (req_err)                         state_d = ST_RESP;
                    else if (req_we && req_funct3 == F3_W) state_d = ST_WR;
                    else                                 state_d = ST_RD;
                end
            end
            ST_RD: state_d = ST_DATA;
            ST_DATA: begin
                mem_wdata = merged;
                mem_rw    = we_q;
                rdata_d   = we_q ? 32'd0 : load_data;
                state_d   = ST_RESP;
            end
            ST_WR: begin
                mem_rw    = 1'b1;
                mem_wdata = wdata_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rdata_d = 32'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_error = resp_valid && err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = {2'b00, addr_q[31:2]};

endmodule
